// File: rtl/i2s_pkg.sv
// i2s_pkg: constants and state encoding shared by the I2S capture path.
//   SAMPLE_W       - receiver sample width
//   BITS_PER_FRAME - SCK cycles per WS frame (32 per channel)
//   state_t        - capture controller state encoding
package i2s_pkg;
   localparam int SAMPLE_W       = 24;
   localparam int BITS_PER_FRAME = 64;
   localparam int BIT_CNT_W      = $clog2(BITS_PER_FRAME);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WARMUP  = 2'd1,
      CAPTURE = 2'd2
   } state_t;
endpackage

// File: rtl/i2s_ws_gen.sv
// i2s_ws_gen: I2S word-select generator.
//   i2s_clk  - SCK, rising edge
//   reset_n  - async active-low reset
//   i_run    - count while high; held at count 0 / ws 0 while low
//   o_ws     - registered word select: 0 for counts 0-31, 1 for 32-63
module i2s_ws_gen
   import i2s_pkg::*;
(
   input  logic i2s_clk,
   input  logic reset_n,
   input  logic i_run,
   output logic o_ws
);
   logic [BIT_CNT_W-1:0] r_cnt;
   logic [BIT_CNT_W-1:0] w_cnt_nxt;
   logic                 r_ws;

   assign w_cnt_nxt = r_cnt + 1'b1;

   // ws follows the MSB of the count it is registered alongside, so it
   // flips on the same edge the count wraps 31->32 and 63->0.
   always_ff @(posedge i2s_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
         r_ws  <= 1'b0;
      end else if (!i_run) begin
         r_cnt <= '0;
         r_ws  <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_ws  <= w_cnt_nxt[BIT_CNT_W-1];
      end
   end

   assign o_ws = r_ws;
endmodule

// File: rtl/i2s_capture_ctrl.sv
// i2s_capture_ctrl: WS generation, microphone warm-up hold-off, two-bank
// left-channel capture and valid/ack hand-off of full banks to the FFT.
//   i2s_clk, reset_n          - SCK and async active-low reset
//   enable                    - run capture; low returns to IDLE, clears state
//   ws                        - word select to mic and receiver
//   sample_in/sample_valid_in - receiver sample and its per-frame strobe
//   buf_we/bank/addr/data     - registered frame-buffer write port
//   frame_valid/frame_bank    - full bank offered to consumer
//   frame_ack                 - consumer releases frame_bank
//   overrun                   - sticky: sample dropped, both banks full
//   capturing                 - high in CAPTURE
module i2s_capture_ctrl #(
   parameter int SAMPLE_W      = 24,
   parameter int FRAME_LEN     = 512,
   parameter int ADDR_W        = 9,
   parameter int WARMUP_FRAMES = 2400
) (
   input  logic                i2s_clk,
   input  logic                reset_n,
   input  logic                enable,
   output logic                ws,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid_in,
   output logic                buf_we,
   output logic                buf_bank,
   output logic [ADDR_W-1:0]   buf_addr,
   output logic [SAMPLE_W-1:0] buf_data,
   output logic                frame_valid,
   output logic                frame_bank,
   input  logic                frame_ack,
   output logic                overrun,
   output logic                capturing
);
   import i2s_pkg::*;

   localparam int                WCNT_W    = $clog2(WARMUP_FRAMES + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
   localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'(WARMUP_FRAMES - 1);

   state_t                r_state, w_state_nxt;
   logic [WCNT_W-1:0]     r_warm_cnt;
   logic [ADDR_W-1:0]     r_addr;
   logic                  r_wb, r_rb;
   logic [1:0]            r_bank_full, w_full_nxt;
   logic                  r_buf_we, r_buf_bank;
   logic [ADDR_W-1:0]     r_buf_addr;
   logic [SAMPLE_W-1:0]   r_buf_data;
   logic                  r_overrun;
   logic                  w_wr, w_drop, w_fv, w_ack, w_bank_done, w_run;

   assign w_fv  = r_bank_full[r_rb];
   assign w_ack = frame_ack && w_fv;
   // A bank is marked full one edge after its last word is issued, so the
   // word is committed before frame_valid can be seen.
   assign w_bank_done = r_buf_we && (r_buf_addr == LAST_ADDR);
   assign w_run = enable && (r_state != IDLE);

   i2s_ws_gen u_ws_gen (
      .i2s_clk (i2s_clk),
      .reset_n (reset_n),
      .i_run   (w_run),
      .o_ws    (ws)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_wr        = 1'b0;
      w_drop      = 1'b0;
      if (!enable) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE:    w_state_nxt = WARMUP;
            WARMUP:  if (sample_valid_in && r_warm_cnt == WARM_LAST) w_state_nxt = CAPTURE;
            CAPTURE: begin
               w_wr   = sample_valid_in && !r_bank_full[r_wb];
               w_drop = sample_valid_in &&  r_bank_full[r_wb];
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Completion and ack always target different banks, so both apply.
   always_comb begin
      w_full_nxt = r_bank_full;
      if (w_bank_done) w_full_nxt[r_buf_bank] = 1'b1;
      if (w_ack)       w_full_nxt[r_rb]       = 1'b0;
   end

   always_ff @(posedge i2s_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i2s_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_warm_cnt  <= '0;
         r_addr      <= '0;
         r_wb        <= 1'b0;
         r_rb        <= 1'b0;
         r_bank_full <= 2'b00;
         r_buf_we    <= 1'b0;
         r_buf_bank  <= 1'b0;
         r_buf_addr  <= '0;
         r_buf_data  <= '0;
         r_overrun   <= 1'b0;
      end else begin
         r_buf_we <= w_wr;
         if (w_state_nxt == IDLE) begin
            // Any partially written bank is abandoned here.
            r_warm_cnt  <= '0;
            r_addr      <= '0;
            r_wb        <= 1'b0;
            r_rb        <= 1'b0;
            r_bank_full <= 2'b00;
            r_overrun   <= 1'b0;
         end else begin
            if (r_state == WARMUP && sample_valid_in) r_warm_cnt <= r_warm_cnt + 1'b1;
            if (w_wr) begin
               r_buf_bank <= r_wb;
               r_buf_addr <= r_addr;
               r_buf_data <= sample_in;
               if (r_addr == LAST_ADDR) begin
                  r_addr <= '0;
                  r_wb   <= ~r_wb;
               end else begin
                  r_addr <= r_addr + 1'b1;
               end
            end
            if (w_drop) r_overrun <= 1'b1;
            r_bank_full <= w_full_nxt;
            if (w_ack) r_rb <= ~r_rb;
         end
      end
   end

   assign buf_we      = r_buf_we;
   assign buf_bank    = r_buf_bank;
   assign buf_addr    = r_buf_addr;
   assign buf_data    = r_buf_data;
   assign frame_valid = w_fv;
   assign frame_bank  = r_rb;
   assign overrun     = r_overrun;
   assign capturing   = (r_state == CAPTURE);
endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// tb_i2s_capture_ctrl: directed bench for i2s_capture_ctrl with
// FRAME_LEN = 8 and WARMUP_FRAMES = 2.
module tb_i2s_capture_ctrl;
   localparam int SW = 24;
   localparam int AW = 3;

   logic          i2s_clk = 1'b0;
   logic          reset_n, enable, sample_valid_in, frame_ack;
   logic [SW-1:0] sample_in;
   logic          ws, buf_we, buf_bank, frame_valid, frame_bank, overrun, capturing;
   logic [AW-1:0] buf_addr;
   logic [SW-1:0] buf_data;

   int n_chk = 0;
   int n_err = 0;
   int n_smp = 0;

   i2s_capture_ctrl #(
      .SAMPLE_W(SW), .FRAME_LEN(8), .ADDR_W(AW), .WARMUP_FRAMES(2)
   ) dut (
      .i2s_clk(i2s_clk), .reset_n(reset_n), .enable(enable), .ws(ws),
      .sample_in(sample_in), .sample_valid_in(sample_valid_in),
      .buf_we(buf_we), .buf_bank(buf_bank), .buf_addr(buf_addr), .buf_data(buf_data),
      .frame_valid(frame_valid), .frame_bank(frame_bank), .frame_ack(frame_ack),
      .overrun(overrun), .capturing(capturing)
   );

   always #5 i2s_clk = ~i2s_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i2s_clk);
      #1;
   endtask

   // One receiver strobe; checks the write port in the following cycle.
   task automatic wr(input logic exp_we, input logic exp_bank, input int exp_addr);
      logic [SW-1:0] d;
      n_smp++;
      d = 24'hC0DE00 + SW'(n_smp);
      sample_in = d;
      sample_valid_in = 1'b1;
      tick();
      sample_valid_in = 1'b0;
      chk($sformatf("we_s%0d", n_smp), buf_we, exp_we);
      if (exp_we) begin
         chk($sformatf("bank_s%0d", n_smp), buf_bank, exp_bank);
         chk($sformatf("addr_s%0d", n_smp), buf_addr, exp_addr);
         chk($sformatf("data_s%0d", n_smp), buf_data, d);
      end
   endtask

   task automatic ack();
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; enable = 1'b0; sample_valid_in = 1'b0;
      frame_ack = 1'b0; sample_in = '0;
      repeat (3) tick();
      chk("rst_ws", ws, 0);       chk("rst_we", buf_we, 0);
      chk("rst_fv", frame_valid, 0); chk("rst_ovr", overrun, 0);
      chk("rst_cap", capturing, 0);  chk("rst_addr", buf_addr, 0);
      chk("rst_data", buf_data, 0);  chk("rst_fb", frame_bank, 0);
      reset_n = 1'b1;
      tick();

      // WS timing: entry to WARMUP at edge e, ws rises at e+32, falls at e+64
      enable = 1'b1;
      tick();
      chk("ws_e0", ws, 0);
      for (int k = 1; k <= 64; k++) begin
         tick();
         if (k == 31) chk("ws_e31", ws, 0);
         if (k == 32) chk("ws_e32", ws, 1);
         if (k == 63) chk("ws_e63", ws, 1);
         if (k == 64) chk("ws_e64", ws, 0);
      end
      chk("warm_cap", capturing, 0);

      // ack with nothing valid is ignored
      ack();
      chk("ack_nv_fb", frame_bank, 0);
      chk("ack_nv_fv", frame_valid, 0);

      // warm-up: two strobes discarded
      wr(0, 0, 0); chk("cap_w1", capturing, 0); tick();
      wr(0, 0, 0); chk("cap_w2", capturing, 1); tick();

      // bank 0 fill
      for (int a = 0; a < 7; a++) begin wr(1, 0, a); tick(); end
      wr(1, 0, 7);
      chk("fv_t1", frame_valid, 0);
      tick();
      chk("fv_t2", frame_valid, 1);
      chk("fb_t2", frame_bank, 0);

      // bank 1 fill, no ack
      for (int a = 0; a < 8; a++) begin wr(1, 1, a); tick(); end
      chk("fv_both", frame_valid, 1);
      chk("fb_both", frame_bank, 0);
      chk("ovr_pre", overrun, 0);
      wr(0, 0, 0);
      chk("ovr_set", overrun, 1);
      tick();

      // release both banks; third ack ignored
      ack(); chk("ack0_fb", frame_bank, 1); chk("ack0_fv", frame_valid, 1);
      ack(); chk("ack1_fb", frame_bank, 0); chk("ack1_fv", frame_valid, 0);
      ack(); chk("ack2_fb", frame_bank, 0);
      wr(1, 0, 0); tick();
      for (int a = 1; a < 8; a++) begin wr(1, 0, a); tick(); end
      for (int a = 0; a < 7; a++) begin wr(1, 1, a); tick(); end

      // bank 1 completes on the same edge bank 0 is acked
      wr(1, 1, 7);
      ack();
      chk("sim_fv", frame_valid, 1);
      chk("sim_fb", frame_bank, 1);
      wr(1, 0, 0); tick();
      for (int a = 1; a < 5; a++) begin wr(1, 0, a); tick(); end
      chk("ovr_sticky", overrun, 1);

      // drop enable at addr 5
      enable = 1'b0;
      tick();
      chk("dis_ws", ws, 0);        chk("dis_ovr", overrun, 0);
      chk("dis_fv", frame_valid, 0); chk("dis_cap", capturing, 0);
      chk("dis_fb", frame_bank, 0);
      tick();
      enable = 1'b1;
      tick();
      wr(0, 0, 0); tick();
      wr(0, 0, 0); tick();
      wr(1, 0, 0); chk("re_fv", frame_valid, 0); tick();
      wr(1, 0, 1);

      // async reset between edges
      #2 reset_n = 1'b0;
      #1;
      chk("ar_ws", ws, 0);         chk("ar_we", buf_we, 0);
      chk("ar_bank", buf_bank, 0); chk("ar_addr", buf_addr, 0);
      chk("ar_data", buf_data, 0); chk("ar_fv", frame_valid, 0);
      chk("ar_fb", frame_bank, 0); chk("ar_ovr", overrun, 0);
      chk("ar_cap", capturing, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
